flash_attn_tile_sched: RTL
==========================

# flash_attn_tile_sched

Tile scheduler for the flash-attention datapath. It runs the outer loop over Q row blocks and the inner loop over K/V column blocks. For each step it drives req/ack handshakes to the BRAM loader, the tile compute engine and the final normalize/write-back stage, then pulses `O_ATTN_END` when the whole sequence is processed. It sits between the top-level control and the attention datapath, replacing ad-hoc sequencing in the top.

## Interface
- `SEQ_LEN`, 64: sequence length in tokens; multiple of `BR` and `BC`.
- `BR`, 16: Q rows per block; `NQ = SEQ_LEN/BR`.
- `BC`, 16: K/V rows per block; `NKV = SEQ_LEN/BC`.
- `IDX_W`, derived: `max(1, $clog2(max(NQ,NKV)))`.
- `I_CLK` in 1: sole clock; all logic on rising edge.
- `I_RST` in 1: synchronous, active-high reset.
- `I_START` in 1: start request, sampled only in IDLE.
- `O_BUSY` out 1: high in every non-IDLE state.
- `O_ATTN_END` out 1: one-cycle completion pulse.
- `O_Q_IDX` out IDX_W: current Q block index.
- `O_KV_IDX` out IDX_W: current K/V block index.
- `O_LDQ_REQ` / `I_LDQ_ACK` out/in 1: load Q block `O_Q_IDX`.
- `O_LDKV_REQ` / `I_LDKV_ACK` out/in 1: load K/V block `O_KV_IDX`.
- `O_TILE_REQ` / `I_TILE_ACK` out/in 1: compute tile for (Q, KV).
- `O_FIRST_KV` out 1: qualifies `O_TILE_REQ`; engine initializes running max/sum.
- `O_LAST_KV` out 1: qualifies `O_TILE_REQ`; last KV tile for this Q block.
- `O_FIN_REQ` / `I_FIN_ACK` out/in 1: normalize and write back the O block for `O_Q_IDX`.
- `O_CYC_CNT` out 32: busy-cycle performance counter.

## Operation
- States: IDLE, LOAD_Q, LOAD_KV, TILE, FINAL, DONE. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE: `I_START`=1 → LOAD_Q, Q=0, KV=0, counter cleared.
- LOAD_Q: `O_LDQ_REQ`=1; on ack → LOAD_KV.
- LOAD_KV: `O_LDKV_REQ`=1; on ack → TILE.
- TILE: `O_TILE_REQ`=1, `O_FIRST_KV`=(KV==0), `O_LAST_KV`=(KV==last). On ack:
  - last KV → FINAL;
  - otherwise KV+1 → LOAD_KV.
- FINAL: `O_FIN_REQ`=1. On ack:
  - Q==NQ-1 → DONE;
  - otherwise Q+1, KV=0 → LOAD_Q.
- DONE: `O_ATTN_END`=1 for exactly one cycle → IDLE. Indices hold their final values until the next start.
- Handshake rules:
  - A req is a level, high for every cycle its state is active.
  - An ack is sampled only while the matching req is high. Ack=1 at an edge completes the phase, and the req is low or the next req is high in the following cycle.
  - Acks on an inactive channel are ignored.
  - Ack may be tied high; each phase then lasts one cycle.
- Last KV index is `NKV-1` (see Configuration for the alternative).
- `I_START` while busy: ignored.
- Counter: increments every cycle `O_BUSY`=1, including DONE; saturates at `32'hFFFF_FFFF`; holds in IDLE.
- Reset values: state IDLE; all req outputs, `O_BUSY`, `O_ATTN_END`, `O_FIRST_KV`, `O_LAST_KV` = 0; indices 0; counter 0.
- Reset mid-operation: the next cycle is IDLE with all reqs low. In-flight acks are discarded, with no completion pulse.

## Timing
- Accept `I_START` at edge 0: LOAD_Q active in cycle 1, `O_BUSY` rises in cycle 1.
- Minimum phase length is one cycle. Each wait cycle without ack adds exactly one cycle.
- With all acks tied high, cycles from start to `O_ATTN_END` = `NQ*(2 + 2*K) + 1`, where K is the KV tiles per Q block. The `O_ATTN_END` cycle is counted in `O_CYC_CNT`.
- The counter value is final in the cycle after `O_ATTN_END`.
- `I_START` high in the `O_ATTN_END` cycle is ignored; the earliest restart is sampled in the first IDLE cycle.

## Configuration
- `FLASH_SCHED_CAUSAL_EN` defined: causal block skipping.
  - The last KV index for Q block i is `min(i, NKV-1)`, so K/V blocks strictly above the diagonal are never loaded or computed.
  - `BR` must equal `BC`; elaborate-time `$error` otherwise.
- Undefined: every Q block visits all `NKV` K/V blocks.

## Test plan
- Reset/idle: assert `I_RST` for 3 cycles, no start → all outputs 0, `O_CYC_CNT`=0, no req ever rises.
- Full run, acks tied high, `SEQ_LEN`=64, `BR`=`BC`=16 → `O_ATTN_END` in cycle 41 after start. The bench checks:
  - 4 LDQ, 16 LDKV, 16 TILE and 4 FIN handshakes;
  - `O_FIRST_KV` at KV=0 and `O_LAST_KV` at KV=3;
  - `O_CYC_CNT`=41.
- Random ack delays of 0–5 cycles → same handshake sequence and indices. `O_CYC_CNT` = 41 + total inserted wait cycles. Reqs stay stable while waiting.
- Causal build, `SEQ_LEN`=32, `BR`=`BC`=16, acks high → (Q,KV) tiles (0,0), (1,0), (1,1) only; `O_ATTN_END` at cycle 11.
- Robustness: `I_RST` asserted during TILE with `I_TILE_ACK`=1 → IDLE next cycle, reqs 0, no `O_ATTN_END`. `I_START` pulsed while busy → ignored. Stray acks on inactive channels → no state change.

Source files
------------

// File: rtl/flash_attn_tile_sched_if.sv
`default_nettype none
// ==========================================================================
// flash_attn_tile_sched_if : control/handshake bundle of the tile scheduler
// Revision 1.0
// ==========================================================================
interface flash_attn_tile_sched_if #(
  parameter int SEQ_LEN = 64,
  parameter int BR      = 16,
  parameter int BC      = 16
);
  localparam int NQ    = SEQ_LEN / BR;
  localparam int NKV   = SEQ_LEN / BC;
  localparam int MAXN  = (NQ > NKV) ? NQ : NKV;
  localparam int IDX_W = ($clog2(MAXN) > 1) ? $clog2(MAXN) : 1;

  logic             I_START;
  logic             O_BUSY;
  logic             O_ATTN_END;
  logic [IDX_W-1:0] O_Q_IDX;
  logic [IDX_W-1:0] O_KV_IDX;
  logic             O_LDQ_REQ;
  logic             I_LDQ_ACK;
  logic             O_LDKV_REQ;
  logic             I_LDKV_ACK;
  logic             O_TILE_REQ;
  logic             I_TILE_ACK;
  logic             O_FIRST_KV;
  logic             O_LAST_KV;
  logic             O_FIN_REQ;
  logic             I_FIN_ACK;
  logic [31:0]      O_CYC_CNT;

  modport master (
    input  I_START, I_LDQ_ACK, I_LDKV_ACK, I_TILE_ACK, I_FIN_ACK,
    output O_BUSY, O_ATTN_END, O_Q_IDX, O_KV_IDX, O_LDQ_REQ, O_LDKV_REQ,
           O_TILE_REQ, O_FIRST_KV, O_LAST_KV, O_FIN_REQ, O_CYC_CNT
  );

  modport slave (
    output I_START, I_LDQ_ACK, I_LDKV_ACK, I_TILE_ACK, I_FIN_ACK,
    input  O_BUSY, O_ATTN_END, O_Q_IDX, O_KV_IDX, O_LDQ_REQ, O_LDKV_REQ,
           O_TILE_REQ, O_FIRST_KV, O_LAST_KV, O_FIN_REQ, O_CYC_CNT
  );
endinterface
`default_nettype wire

// File: rtl/flash_attn_tile_sched.sv
`default_nettype none
// ==========================================================================
// flash_attn_tile_sched : Q-block / KV-block loop sequencer for flash attention
// Optional causal block skipping: FLASH_SCHED_CAUSAL_EN.   Revision 1.0
// ==========================================================================
module flash_attn_tile_sched #(
  parameter int SEQ_LEN = 64,
  parameter int BR      = 16,
  parameter int BC      = 16
) (
  input  wire logic                      I_CLK,
  input  wire logic                      I_RST,
  flash_attn_tile_sched_if.master        if_sched
);
  localparam int NQ    = SEQ_LEN / BR;
  localparam int NKV   = SEQ_LEN / BC;
  localparam int MAXN  = (NQ > NKV) ? NQ : NKV;
  localparam int IDX_W = ($clog2(MAXN) > 1) ? $clog2(MAXN) : 1;

  localparam logic [IDX_W-1:0] c_Q_LAST  = IDX_W'(NQ - 1);
  localparam logic [IDX_W-1:0] c_KV_LAST = IDX_W'(NKV - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LOAD_Q  = 3'd1;
  localparam logic [2:0] c_LOAD_KV = 3'd2;
  localparam logic [2:0] c_TILE    = 3'd3;
  localparam logic [2:0] c_FINAL   = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_q;
  logic [IDX_W-1:0] r_kv;
  logic [31:0]      r_cnt;
  logic [IDX_W-1:0] w_kv_last;

`ifdef FLASH_SCHED_CAUSAL_EN
  if (BR != BC) begin : g_causal_shape_check
    $error("flash_attn_tile_sched: causal skipping needs BR == BC");
  end
  // Diagonal tile is the last one visited for each Q block
  assign w_kv_last = (r_q < c_KV_LAST) ? r_q : c_KV_LAST;
`else
  assign w_kv_last = c_KV_LAST;
`endif

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= c_IDLE;
      r_q     <= '0;
      r_kv    <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state != c_IDLE && r_cnt != 32'hFFFF_FFFF) begin
        r_cnt <= r_cnt + 32'd1;
      end
      case (r_state)
        c_IDLE: begin
          if (if_sched.I_START) begin
            r_state <= c_LOAD_Q;
            r_q     <= '0;
            r_kv    <= '0;
            r_cnt   <= '0;
          end
        end
        c_LOAD_Q: begin
          if (if_sched.I_LDQ_ACK) r_state <= c_LOAD_KV;
        end
        c_LOAD_KV: begin
          if (if_sched.I_LDKV_ACK) r_state <= c_TILE;
        end
        c_TILE: begin
          if (if_sched.I_TILE_ACK) begin
            if (r_kv == w_kv_last) begin
              r_state <= c_FINAL;
            end else begin
              r_kv    <= r_kv + 1'b1;
              r_state <= c_LOAD_KV;
            end
          end
        end
        c_FINAL: begin
          if (if_sched.I_FIN_ACK) begin
            if (r_q == c_Q_LAST) begin
              r_state <= c_DONE;
            end else begin
              r_q     <= r_q + 1'b1;
              r_kv    <= '0;
              r_state <= c_LOAD_Q;
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state; no input reaches an output
  assign if_sched.O_BUSY     = (r_state != c_IDLE);
  assign if_sched.O_ATTN_END = (r_state == c_DONE);
  assign if_sched.O_LDQ_REQ  = (r_state == c_LOAD_Q);
  assign if_sched.O_LDKV_REQ = (r_state == c_LOAD_KV);
  assign if_sched.O_TILE_REQ = (r_state == c_TILE);
  assign if_sched.O_FIN_REQ  = (r_state == c_FINAL);
  assign if_sched.O_FIRST_KV = (r_state == c_TILE) && (r_kv == '0);
  assign if_sched.O_LAST_KV  = (r_state == c_TILE) && (r_kv == w_kv_last);
  assign if_sched.O_Q_IDX    = r_q;
  assign if_sched.O_KV_IDX   = r_kv;
  assign if_sched.O_CYC_CNT  = r_cnt;

endmodule
`default_nettype wire
